gomoku_input_ctrl: RTL and testbench

Front-panel input controller for the gomoku board. It conditions five raw push-buttons into clean one-cycle pulses using per-button synchronise, debounce and rising-edge logic. It resolves simultaneous presses by fixed priority and drives the cursor position on the board. A centre press hands the chosen cell to the game engine over a valid/ready handshake, and navigation is locked until the engine returns the turn.

---
 rtl/gomoku_pkg.sv | 37 +++
 rtl/gomoku_input_ctrl_btn_cond.sv | 107 ++++++++++
 rtl/gomoku_input_ctrl.sv | 143 ++++++++++++++
 tb/tb_gomoku_input_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// Shared types and constants for the gomoku front-panel input controller.
// Optional feature macro: GOMOKU_AUTOREPEAT_EN (auto-repeat of held direction buttons).
package gomoku_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    NAV  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Resolved command after priority selection among simultaneous pulses
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_CENTER = 3'd1,
    CMD_UP     = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_LEFT   = 3'd4,
    CMD_RIGHT  = 3'd5
  } cmd_e;

  // Button indices into the conditioned pulse vector
  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_L   = 3;
  localparam int BTN_R   = 4;
  localparam int NUM_BTN = 5;

  localparam int BOARD_N_DEF = 15;

  // Width of a board coordinate for a board of side n
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gomoku_input_ctrl_btn_cond.sv
// Per-button conditioning: 2-FF synchroniser, debounce, rising-edge pulse.
// With GOMOKU_AUTOREPEAT_EN defined and RPT_EN set, a held button also emits
// a pulse REPEAT_DLY cycles after its press pulse and every REPEAT_PER after that.
module btn_cond #(
  parameter int DEBOUNCE_CYC = 250000
`ifdef GOMOKU_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 15000000,
  parameter bit RPT_EN       = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          acc;
  logic          acc_d;
  logic [DW-1:0] cnt;
  logic          press;
  logic          next_pulse;

  // First cycle in which the accepted level is high after having been low
  assign press = acc & ~acc_d;

  // Two-stage synchroniser for the asynchronous raw button
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count while the synchronised level disagrees with the accepted one,
  // restart whenever they agree again, and accept after DEBOUNCE_CYC stable cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (sync2 == acc) begin
      cnt <= '0;
    end else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
      acc <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef GOMOKU_AUTOREPEAT_EN
  logic rpt_fire;

  if (RPT_EN) begin : g_rpt
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rpt_cnt;
    logic          held;

    // Held means accepted high and the synchroniser still sees the button down,
    // so a release stops repeats at once rather than after the release debounce
    assign held     = acc & sync2;
    assign rpt_fire = held & ~press & (rpt_cnt == '0);

    // Repeat timer: reload on the press pulse and after each repeat, count down while held
    always_ff @(posedge clk) begin
      if (!rst) begin
        rpt_cnt <= RW'(REPEAT_DLY - 1);
      end else if (!held || press) begin
        rpt_cnt <= RW'(REPEAT_DLY - 1);
      end else if (rpt_fire) begin
        rpt_cnt <= RW'(REPEAT_PER - 1);
      end else begin
        rpt_cnt <= rpt_cnt - 1'b1;
      end
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end

  assign next_pulse = press | rpt_fire;
`else
  assign next_pulse = press;
`endif

  // Registered one-cycle output pulse and accepted-level history
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_d <= 1'b0;
      pulse <= 1'b0;
    end else begin
      acc_d <= acc;
      pulse <= next_pulse;
    end
  end

endmodule

// File: rtl/gomoku_input_ctrl.sv
// Gomoku front-panel input controller: five conditioned buttons, fixed
// priority, wrapping cursor and a valid/ready move handoff to the engine.
// Optional feature macro: GOMOKU_AUTOREPEAT_EN (direction auto-repeat).
module gomoku_input_ctrl
  import gomoku_pkg::*;
#(
  parameter int BOARD_N      = BOARD_N_DEF,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 15000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_center,
  input  logic                          turn_human,
  input  logic                          move_ready,
  output logic [coord_w(BOARD_N)-1:0]   cur_x,
  output logic [coord_w(BOARD_N)-1:0]   cur_y,
  output logic                          move_valid,
  output logic [coord_w(BOARD_N)-1:0]   move_x,
  output logic [coord_w(BOARD_N)-1:0]   move_y,
  output logic                          busy
);

  localparam int            CW    = coord_w(BOARD_N);
  localparam logic [CW-1:0] MAX_C = CW'(BOARD_N - 1);
  localparam logic [CW-1:0] MID_C = CW'(BOARD_N / 2);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] pulse;
  cmd_e               cmd;
  state_e             state_q;
  state_e             state_d;
  logic               th_prev;
  logic               turn_rise;
  logic [CW-1:0]      cur_x_d;
  logic [CW-1:0]      cur_y_d;
  logic [CW-1:0]      move_x_d;
  logic [CW-1:0]      move_y_d;

  assign raw[BTN_C] = btn_center;
  assign raw[BTN_U] = btn_up;
  assign raw[BTN_D] = btn_down;
  assign raw[BTN_L] = btn_left;
  assign raw[BTN_R] = btn_right;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef GOMOKU_AUTOREPEAT_EN
      ,
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER),
      .RPT_EN       (bit'(i != BTN_C))
`endif
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .pulse (pulse[i])
    );
  end

  assign turn_rise = turn_human & ~th_prev;

  function automatic logic [CW-1:0] dec_wrap(input logic [CW-1:0] v);
    return (v == '0) ? MAX_C : v - 1'b1;
  endfunction

  function automatic logic [CW-1:0] inc_wrap(input logic [CW-1:0] v);
    return (v == MAX_C) ? '0 : v + 1'b1;
  endfunction

  // Fixed priority: center > up > down > left > right; lower pulses are dropped
  always_comb begin
    cmd = CMD_NONE;
    if      (pulse[BTN_C]) cmd = CMD_CENTER;
    else if (pulse[BTN_U]) cmd = CMD_UP;
    else if (pulse[BTN_D]) cmd = CMD_DOWN;
    else if (pulse[BTN_L]) cmd = CMD_LEFT;
    else if (pulse[BTN_R]) cmd = CMD_RIGHT;
  end

  // Next-state, cursor and move latch decode
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x;
    cur_y_d  = cur_y;
    move_x_d = move_x;
    move_y_d = move_y;
    case (state_q)
      NAV: begin
        case (cmd)
          CMD_CENTER: begin
            if (turn_human) begin
              move_x_d = cur_x;
              move_y_d = cur_y;
              state_d  = REQ;
            end
          end
          CMD_UP:    cur_y_d = dec_wrap(cur_y);
          CMD_DOWN:  cur_y_d = inc_wrap(cur_y);
          CMD_LEFT:  cur_x_d = dec_wrap(cur_x);
          CMD_RIGHT: cur_x_d = inc_wrap(cur_x);
          default:   ;
        endcase
      end
      // move_valid is high for the whole of REQ, so move_ready alone completes the handshake
      REQ:     if (move_ready) state_d = WAIT;
      WAIT:    if (turn_rise)  state_d = NAV;
      default: state_d = NAV;
    endcase
  end

  // State, cursor, move latch and registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= NAV;
      cur_x      <= MID_C;
      cur_y      <= MID_C;
      move_x     <= '0;
      move_y     <= '0;
      move_valid <= 1'b0;
      busy       <= 1'b0;
      th_prev    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x      <= cur_x_d;
      cur_y      <= cur_y_d;
      move_x     <= move_x_d;
      move_y     <= move_y_d;
      move_valid <= (state_d == REQ);
      busy       <= (state_d != NAV);
      th_prev    <= turn_human;
    end
  end

endmodule

// File: tb/tb_gomoku_input_ctrl.sv
// Self-checking bench for gomoku_input_ctrl: a behavioural board model pushes
// expected output events into a queue; a negedge monitor pops and compares.
// Honours GOMOKU_AUTOREPEAT_EN when computing how many pulses a long hold gives.
module tb_gomoku_input_ctrl;

  localparam int N    = 15;
  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
  localparam int CW   = $clog2(N);

  localparam int EV_CUR   = 1;
  localparam int EV_MVR   = 2;
  localparam int EV_MVF   = 3;
  localparam int EV_BUSYF = 4;
  localparam int EV_BUSYR = 5;

  typedef struct {
    int kind;
    int x;
    int y;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic          btn_right = 1'b0, btn_center = 1'b0;
  logic          turn_human = 1'b0;
  logic          move_ready = 1'b0;
  logic [CW-1:0] cur_x, cur_y, move_x, move_y;
  logic          move_valid, busy;

  int  n_checks = 0;
  int  n_pass   = 0;
  ev_t exp_q[$];

  // Behavioural model: cursor, phase (0 navigate, 1 requesting, 2 waiting), engine turn
  int m_x = N / 2, m_y = N / 2, m_phase = 0, m_th = 0, m_req_x = 0, m_req_y = 0;
  bit mon_en = 1'b0;

  gomoku_input_ctrl #(
    .BOARD_N      (N),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DLY   (RDLY),
    .REPEAT_PER   (RPER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .turn_human (turn_human),
    .move_ready (move_ready),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .move_valid (move_valid),
    .move_x     (move_x),
    .move_y     (move_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_ev(input int kind, input int x, input int y);
    ev_t e;
    e.kind = kind;
    e.x    = x;
    e.y    = y;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int kind, input int x, input int y);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, 0);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == EV_CUR || kind == EV_MVR) begin
      check("event_x", x, e.x);
      check("event_y", y, e.y);
    end
  endtask

  // Monitor: turns visible output changes into events and checks the REQ contract
  logic [CW-1:0] p_x, p_y;
  logic          p_mv, p_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cur_x != p_x || cur_y != p_y) got_event(EV_CUR, cur_x, cur_y);
      if (move_valid && !p_mv)          got_event(EV_MVR, move_x, move_y);
      if (!move_valid && p_mv)          got_event(EV_MVF, 0, 0);
      if (!busy && p_busy)              got_event(EV_BUSYF, 0, 0);
      if (busy && !p_busy && !move_valid) got_event(EV_BUSYR, 0, 0);
      if (move_valid && p_mv) begin
        check("req_move_x_stable", move_x, m_req_x);
        check("req_move_y_stable", move_y, m_req_y);
      end
      if (move_valid) check("busy_in_req", busy, 1);
    end
    p_x    = cur_x;
    p_y    = cur_y;
    p_mv   = move_valid;
    p_busy = busy;
  end

  // Number of accepted pulses a clean hold of `hold` sampled cycles produces
  function automatic int n_pulses(input int b, input int hold);
    int n;
    if (b < 0 || hold < DEB + 1) return 0;
    n = 1;
`ifdef GOMOKU_AUTOREPEAT_EN
    if (b != 0)
      for (int t = DEB + 2 + RDLY; t <= hold + 1; t += RPER) n++;
`endif
    return n;
  endfunction

  // Model reaction to one accepted pulse (b: 0 center, 1 up, 2 down, 3 left, 4 right)
  task automatic mdl_pulse(input int b);
    if (m_phase != 0) return;
    case (b)
      0: if (m_th != 0) begin
           m_req_x = m_x;
           m_req_y = m_y;
           m_phase = 1;
           push_ev(EV_MVR, m_x, m_y);
         end
      1: begin m_y = (m_y + N - 1) % N; push_ev(EV_CUR, m_x, m_y); end
      2: begin m_y = (m_y + 1) % N;     push_ev(EV_CUR, m_x, m_y); end
      3: begin m_x = (m_x + N - 1) % N; push_ev(EV_CUR, m_x, m_y); end
      4: begin m_x = (m_x + 1) % N;     push_ev(EV_CUR, m_x, m_y); end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [4:0] mask);
    btn_center = mask[0];
    btn_up     = mask[1];
    btn_down   = mask[2];
    btn_left   = mask[3];
    btn_right  = mask[4];
  endtask

  // Hold buttons in `mask` for `hold` cycles, then release and let it settle
  task automatic press(input logic [4:0] mask, input int hold);
    int b;
    int np;
    b = -1;
    for (int i = 0; i < 5; i++) if (mask[i] && b < 0) b = i;
    np = n_pulses(b, hold);
    for (int k = 0; k < np; k++) mdl_pulse(b);
    @(negedge clk);
    drive(mask);
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic handshake();
    if (m_phase == 1) begin
      m_phase = 2;
      push_ev(EV_MVF, 0, 0);
    end
    @(negedge clk);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_turn(input int v);
    if (v != 0 && m_th == 0 && m_phase == 2) begin
      m_phase = 0;
      push_ev(EV_BUSYF, 0, 0);
    end
    m_th = v;
    @(negedge clk);
    turn_human = (v != 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    int r;
    int y0;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_cur_x", cur_x, N / 2);
    check("reset_cur_y", cur_y, N / 2);
    check("reset_move_valid", move_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_move_x", move_x, 0);
    check("reset_move_y", move_y, 0);
    mon_en = 1'b1;

    // Right held 10 cycles: one step, with the pulse-to-cursor latency measured
    mdl_pulse(4);
    @(negedge clk);
    btn_right = 1'b1;
    k = 0;
    while (cur_x == CW'(N / 2) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("right_press_latency", k, DEB + 4);
    check("cur_x_after_right", cur_x, m_x);
    repeat (2) @(negedge clk);
    btn_right = 1'b0;
    repeat (DEB + 8) @(negedge clk);

    // Two-cycle glitch on left is rejected
    press(5'b01000, 2);
    check("glitch_no_move", cur_x, m_x);

    // Wrap right edge 14 -> 0, then top edge 0 -> 14
    for (int i = 0; i < 7; i++) press(5'b10000, DEB + 3);
    check("x_wraps_to_0", cur_x, 0);
    for (int i = 0; i < 7; i++) press(5'b00010, DEB + 3);
    check("y_reaches_0", cur_y, 0);
    press(5'b00010, DEB + 3);
    check("y_wraps_to_max", cur_y, N - 1);

    // Center while it is not the human's turn is ignored
    press(5'b00001, 10);
    check("center_no_turn_busy", busy, 0);

    // Up and center together with turn_human=1: center wins, cursor unchanged
    set_turn(1);
    press(5'b00011, 10);
    check("req_move_valid", move_valid, 1);
    check("req_cursor_y_kept", cur_y, m_y);

    // REQ held across 5 cycles of move_ready=0, then handshake into WAIT
    repeat (5) @(negedge clk);
    check("req_still_valid", move_valid, 1);
    handshake();
    check("wait_move_valid_low", move_valid, 0);
    check("wait_busy", busy, 1);
    press(5'b10000, DEB + 3);
    check("wait_ignores_right", cur_x, m_x);
    set_turn(0);
    check("turn_low_still_wait", busy, 1);
    set_turn(1);
    check("back_to_nav_busy", busy, 0);

    // Long hold on down: one step, or three with auto-repeat
    y0 = m_y;
    press(5'b00100, 40);
    check("long_hold_down_y", cur_y, (y0 + n_pulses(2, 40)) % N);

    // Randomised play
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 8);
      case (r)
        0, 1, 2, 3, 4: press(5'(1 << r), ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(DEB + 2, 12));
        5, 6:          handshake();
        7:             set_turn((m_th != 0) ? 0 : 1);
        default:       press(5'b00001, $urandom_range(DEB + 2, 12));
      endcase
    end

    // Return to navigation, then reset while a move is pending
    if (m_phase == 1) handshake();
    if (m_phase == 2) begin
      set_turn(0);
      set_turn(1);
    end
    if (m_th == 0) set_turn(1);
    press(5'b00001, DEB + 3);
    check("pre_reset_req", move_valid, 1);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_req_move_valid", move_valid, 0);
    check("reset_in_req_busy", busy, 0);
    check("reset_in_req_cur_x", cur_x, N / 2);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
